// File: rtl/miniCPU_pkg.sv
// miniCPU_pkg: shared widths, halt opcode, instruction word and fetch FSM state.
package miniCPU_pkg;
    localparam int PC_W  = 4;
    localparam int OPC_W = 4;
    localparam int OPD_W = 8;
    localparam logic [OPC_W-1:0] HLT_OPC = 4'hF;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [OPD_W-1:0] operand_1;
        logic [OPD_W-1:0] operand_2;
    } instr_t;

    typedef enum logic [1:0] {RUN, STALL, HALT} fetch_state_t;
endpackage

// File: rtl/instr_rom.sv
// instr_rom: combinational 16-entry program ROM; HLT_ADDR (if in range) turns that entry into HLT.
module instr_rom
    import miniCPU_pkg::*;
#(
    parameter int HLT_ADDR = -1
) (
    input  logic [PC_W-1:0] addr,
    output instr_t          instr
);
    always_comb begin
        case (addr)
            4'h0:    instr = 20'h1_10_01;
            4'h1:    instr = 20'h2_21_12;
            4'h2:    instr = 20'h3_32_23;
            4'h3:    instr = 20'h4_43_34;
            4'h4:    instr = 20'h5_54_45;
            4'h5:    instr = 20'h6_65_56;
            4'h6:    instr = 20'h7_76_67;
            4'h7:    instr = 20'h8_87_78;
            4'h8:    instr = 20'h9_98_89;
            4'h9:    instr = 20'hA_A9_9A;
            4'hA:    instr = 20'hB_BA_AB;
            4'hB:    instr = 20'hC_CB_BC;
            4'hC:    instr = 20'hD_DC_CD;
            4'hD:    instr = 20'hE_ED_DE;
            4'hE:    instr = 20'h0_FE_EF;
            default: instr = 20'h1_0F_F0;
        endcase
        if (int'(addr) == HLT_ADDR) instr.opcode = HLT_OPC;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: miniCPU fetch stage; owns the PC and presents ROM words over valid/ready.
// Define FETCH_JUMP_EN to add the jump_valid/jump_target redirect ports.
module instr_fetch
    import miniCPU_pkg::*;
#(
    parameter int HLT_ADDR = -1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop,
    input  logic             out_ready,
`ifdef FETCH_JUMP_EN
    input  logic             jump_valid,
    input  logic [PC_W-1:0]  jump_target,
`endif
    output logic             out_valid,
    output logic [OPC_W-1:0] opcode,
    output logic [OPD_W-1:0] operand_1,
    output logic [OPD_W-1:0] operand_2,
    output logic [PC_W-1:0]  pc,
    output logic             halted
);
    fetch_state_t    state_q;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, pc_q, jump_pc;
    logic            valid_q, load, jump;
    instr_t          instr_q, rom_word;

    instr_rom #(.HLT_ADDR(HLT_ADDR)) u_rom (.addr(fetch_pc_q), .instr(rom_word));

`ifdef FETCH_JUMP_EN
    assign jump    = jump_valid && state_q != HALT;
    assign jump_pc = jump_target;
`else
    assign jump    = 1'b0;
    assign jump_pc = '0;
`endif

    always_comb begin
        load       = state_q == RUN && !stop && (!valid_q || out_ready) && !jump;
        fetch_pc_d = jump ? jump_pc : load ? fetch_pc_q + PC_W'(1) : fetch_pc_q;
    end

    // A flush drops valid; otherwise a completed handshake without a reload drains it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= '0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= load | (valid_q & ~out_ready & ~jump);
            if (load) begin
                instr_q <= rom_word;
                pc_q    <= fetch_pc_q;
            end
            state_q <= state_q == HALT                      ? HALT :
                       stop                                 ? STALL :
                       (load && rom_word.opcode == HLT_OPC) ? HALT : RUN;
        end
    end

    assign out_valid = valid_q;
    assign opcode    = instr_q.opcode;
    assign operand_1 = instr_q.operand_1;
    assign operand_2 = instr_q.operand_2;
    assign pc        = pc_q;
    assign halted    = state_q == HALT;
endmodule
